// File: rtl/pagemem_arb.sv
// pagemem_arb: arbiter and access sequencer for the shared paged SRAM.
//
// The CPU reaches the SRAM through an 8 KB window; its address is {page, offset}.
// The DMA engine uses a flat 18-bit address. One fixed-length access runs at a time.
// Address, write data and direction are latched when the access is granted.
//
// Ports:
//   i_clk, i_rst                 clock; asynchronous active-high reset
//   i_page                       current page from the page select register
//   i_cpu_*/o_cpu_*              CPU window request (level), data, ready pulse
//   i_dma_*/o_dma_*              DMA request (level), data, ack pulse
//   o_mem_*/i_mem_din            SRAM pins
//   i_cfg_*/o_cfg_do             config register file
//                                  0 ctrl   {dma_prio, dma_en}
//                                  1 status {state==DMA_ACC, state==CPU_ACC, cpu_req}
//                                  2 DMA grant count, 3 CPU grant count
//
// Build option:
//   PAGEMEM_ARB_STATS_EN  enables the saturating grant counters at regs 2 and 3.
//                         Without it, both registers read 0.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | arbitrate between the CPU and DMA requests every cycle
// CPU_ACC  | CPU access on the SRAM pins for WAIT_STATES+1 cycles
// DMA_ACC  | DMA access on the SRAM pins for WAIT_STATES+1 cycles
// DONE     | completion pulse; both requests are ignored
module pagemem_arb #(
    parameter int WAIT_STATES    = 1,
    parameter int MAX_DMA_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_page,
    input  logic        i_cpu_req,
    input  logic        i_cpu_rw,
    input  logic [12:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_di,
    output logic [7:0]  o_cpu_do,
    output logic        o_cpu_ready,
    input  logic        i_dma_req,
    input  logic        i_dma_rw,
    input  logic [17:0] i_dma_addr,
    input  logic [7:0]  i_dma_di,
    output logic [7:0]  o_dma_do,
    output logic        o_dma_ack,
    output logic [17:0] o_mem_addr,
    input  logic [7:0]  i_mem_din,
    output logic [7:0]  o_mem_dout,
    output logic        o_mem_oe,
    output logic        o_mem_we,
    input  logic        i_cfg_cs,
    input  logic        i_cfg_rw,
    input  logic [1:0]  i_cfg_ad,
    input  logic [7:0]  i_cfg_di,
    output logic [7:0]  o_cfg_do
);
    localparam int WW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DMA_ACC = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ctrl;
    logic [2:0]      r_streak;
    logic [WW-1:0]   r_wait;
    logic [17:0]     r_mem_addr;
    logic [7:0]      r_mem_dout;
    logic            r_mem_oe;
    logic            r_mem_we;
    logic [7:0]      r_cpu_do;
    logic [7:0]      r_dma_do;
    logic            r_cpu_ready;
    logic            r_dma_ack;
    logic [7:0]      r_cfg_do;
    logic [7:0]      w_cfg_rdata;
    logic [7:0]      w_reg2;
    logic [7:0]      w_reg3;
    logic            w_dma_eff;
    logic            w_streak_hit;
    logic            w_pick_cpu;
    logic            w_pick_dma;
    logic            w_grant_cpu;
    logic            w_grant_dma;
    logic            w_last;
    logic            w_unused_cfg_di;

    assign w_unused_cfg_di = ^i_cfg_di[7:2];

    // The CPU wins any contention unless DMA has priority and has not yet
    // used up its allowed run of grants while the CPU was waiting.
    assign w_dma_eff    = i_dma_req & r_ctrl[0];
    assign w_streak_hit = (int'(r_streak) >= MAX_DMA_STREAK);
    assign w_pick_cpu   = i_cpu_req & (~w_dma_eff | ~r_ctrl[1] | w_streak_hit);
    assign w_pick_dma   = w_dma_eff & ~w_pick_cpu;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_cpu = 1'b0;
        w_grant_dma = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_cpu) begin
                    w_grant_cpu = 1'b1;
                    w_state_nxt = ST_CPU_ACC;
                end else if (w_pick_dma) begin
                    w_grant_dma = 1'b1;
                    w_state_nxt = ST_DMA_ACC;
                end
            end
            ST_CPU_ACC, ST_DMA_ACC: begin
                if (r_wait == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait      <= '0;
            r_mem_addr  <= '0;
            r_mem_dout  <= '0;
            r_mem_oe    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_do    <= '0;
            r_dma_do    <= '0;
            r_cpu_ready <= 1'b0;
            r_dma_ack   <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_dma_ack   <= 1'b0;
            if (w_grant_cpu) begin
                r_mem_addr <= {i_page, i_cpu_addr};
                r_mem_dout <= i_cpu_di;
                r_mem_oe   <= i_cpu_rw;
                r_mem_we   <= ~i_cpu_rw;
                r_wait     <= WAIT_LOAD;
            end else if (w_grant_dma) begin
                r_mem_addr <= i_dma_addr;
                r_mem_dout <= i_dma_di;
                r_mem_oe   <= i_dma_rw;
                r_mem_we   <= ~i_dma_rw;
                r_wait     <= WAIT_LOAD;
            end else if (w_last) begin
                if (r_state == ST_CPU_ACC) begin
                    if (r_mem_oe) r_cpu_do <= i_mem_din;
                    r_cpu_ready <= 1'b1;
                end else begin
                    if (r_mem_oe) r_dma_do <= i_mem_din;
                    r_dma_ack <= 1'b1;
                end
                r_mem_oe <= 1'b0;
                r_mem_we <= 1'b0;
            end else if (r_state == ST_CPU_ACC || r_state == ST_DMA_ACC) begin
                r_wait <= r_wait - 1'b1;
            end
        end
    end

    // Streak counts DMA grants taken while the CPU was kept waiting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_streak <= '0;
        end else if (w_grant_cpu) begin
            r_streak <= '0;
        end else if (w_grant_dma) begin
            if (!i_cpu_req)             r_streak <= '0;
            else if (r_streak != 3'd7)  r_streak <= r_streak + 3'd1;
        end
    end

`ifdef PAGEMEM_ARB_STATS_EN
    logic [7:0] r_dma_cnt;
    logic [7:0] r_cpu_cnt;
    logic       w_stats_clr;

    assign w_stats_clr = i_cfg_cs & ~i_cfg_rw & i_cfg_ad[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dma_cnt <= '0;
            r_cpu_cnt <= '0;
        end else if (w_stats_clr) begin
            r_dma_cnt <= '0;
            r_cpu_cnt <= '0;
        end else begin
            if (w_grant_dma && r_dma_cnt != 8'hFF) r_dma_cnt <= r_dma_cnt + 8'd1;
            if (w_grant_cpu && r_cpu_cnt != 8'hFF) r_cpu_cnt <= r_cpu_cnt + 8'd1;
        end
    end

    assign w_reg2 = r_dma_cnt;
    assign w_reg3 = r_cpu_cnt;
`else
    assign w_reg2 = 8'd0;
    assign w_reg3 = 8'd0;
`endif

    always_comb begin
        w_cfg_rdata = 8'd0;
        case (i_cfg_ad)
            2'd0:    w_cfg_rdata = {6'd0, r_ctrl};
            2'd1:    w_cfg_rdata = {5'd0, r_state == ST_DMA_ACC, r_state == ST_CPU_ACC, i_cpu_req};
            2'd2:    w_cfg_rdata = w_reg2;
            default: w_cfg_rdata = w_reg3;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl   <= '0;
            r_cfg_do <= '0;
        end else if (i_cfg_cs) begin
            if (i_cfg_rw)              r_cfg_do <= w_cfg_rdata;
            else if (i_cfg_ad == 2'd0) r_ctrl   <= i_cfg_di[1:0];
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_dout  = r_mem_dout;
    assign o_mem_oe    = r_mem_oe;
    assign o_mem_we    = r_mem_we;
    assign o_cpu_do    = r_cpu_do;
    assign o_dma_do    = r_dma_do;
    assign o_cpu_ready = r_cpu_ready;
    assign o_dma_ack   = r_dma_ack;
    assign o_cfg_do    = r_cfg_do;

endmodule

// File: doc/pagemem_arb.md
Name: pagemem_arb

Overview:
Arbiter and sequencer for the shared paged SRAM. Two requesters share the SRAM: the CPU, through its 8 KB paged window, and the DMA engine, through a flat 18-bit address. The block latches the current 5-bit page at grant time and runs a fixed-length SRAM access. It stalls the losing requester and exposes a small CPU-visible config register file. It sits between the page select register, the CPU bus decoder, the DMA engine and the SRAM pins.

Parameters:
WAIT_STATES, 1, extra SRAM cycles per access; an access lasts WAIT_STATES+1 cycles.
MAX_DMA_STREAK, 4, consecutive DMA grants allowed while the CPU is waiting before the CPU is forced in.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
page  in  5  current page from page select register
cpu_req  in  1  CPU window access request, level
cpu_rw  in  1  1=read, 0=write
cpu_addr  in  13  offset within window
cpu_di  in  8  CPU write data
cpu_do  out  8  CPU read data
cpu_ready  out  1  one-cycle completion pulse
dma_req  in  1  DMA request, level
dma_rw  in  1  1=read, 0=write
dma_addr  in  18  flat SRAM address
dma_di  in  8  DMA write data
dma_do  out  8  DMA read data
dma_ack  out  1  one-cycle completion pulse
mem_addr  out  18  SRAM address
mem_din  in  8  SRAM read data
mem_dout  out  8  SRAM write data
mem_oe  out  1  SRAM output enable
mem_we  out  1  SRAM write enable
cfg_cs  in  1  config register select
cfg_rw  in  1  1=read, 0=write
cfg_ad  in  2  config register index
cfg_di  in  8  config write data
cfg_do  out  8  config read data

Behaviour:
- Reset (async, any state, including mid-access): FSM=IDLE. mem_addr, mem_dout, cpu_do, dma_do and cfg_do are 0. mem_oe, mem_we, cpu_ready and dma_ack are 0. ctrl is 0. The streak counter is 0. An aborted access is not completed and no ack is issued.
- Config regs, synchronous on cfg_cs:
  - Reg 0 ctrl: bit0 dma_en, bit1 dma_prio. Other bits read 0.
  - Reg 1: read-only status {5'b0, state==DMA_ACC, state==CPU_ACC, cpu_req}.
  - Reg 3 reads 0.
  - Reads load cfg_do on the clock edge. Writes to read-only regs are ignored.
- FSM states: IDLE, CPU_ACC, DMA_ACC, DONE.
- IDLE arbitration, evaluated every cycle. dma_req is effective only when dma_en=1.
  - Only one request active: grant it.
  - Both active, dma_prio=0: CPU wins.
  - Both active, dma_prio=1: DMA wins unless streak>=MAX_DMA_STREAK, in which case CPU wins.
- Streak counter, 3 bits, saturating:
  - Increments on each DMA grant while cpu_req=1.
  - Clears on a CPU grant, or when a DMA grant occurs with cpu_req=0.
- Grant edge actions:
  - CPU grant: mem_addr={page,cpu_addr}, mem_dout=cpu_di.
  - DMA grant: mem_addr=dma_addr, mem_dout=dma_di.
  - mem_oe=rw, mem_we=~rw.
  - Address, data and page are frozen for the whole access; page changes mid-access have no effect.
- *_ACC: a wait counter runs WAIT_STATES+1 cycles. On the last cycle edge:
  - For a read, capture mem_din into cpu_do or dma_do.
  - Drop mem_oe and mem_we, go to DONE, pulse cpu_ready or dma_ack high for exactly the DONE cycle.
- DONE:
  - Both requests are ignored for this one cycle.
  - Requesters must deassert req by the edge ending DONE. A req still high in the following IDLE cycle is a new access.
  - DONE always returns to IDLE.
- Latency: grant is at most 1 cycle after req when idle. ready/ack asserts WAIT_STATES+2 cycles after grant.
- Clearing dma_en while DMA_ACC is active: the current access completes normally and no further DMA grants are made.
- A config write to ctrl in the same cycle as arbitration takes effect from the next cycle.

Optional Feature:
PAGEMEM_ARB_STATS_EN
- Defined: reg 2 is an 8-bit saturating count of DMA grants and reg 3 is an 8-bit saturating count of CPU grants. Any write to reg 2 or reg 3 clears both counters. Both reset to 0.
- Undefined: reg 2 and reg 3 read 0, the counter logic is absent, and writes are ignored.

Test Plan:
1. WAIT_STATES=1. page=5'h13, CPU read cpu_addr=13'h0ABC, mem_din=8'h5A -> mem_addr=18'h26ABC, mem_oe high 2 cycles, cpu_ready pulses 1 cycle, cpu_do=8'h5A.
2. dma_en=1, dma_prio=0, cpu_req and dma_req raised in the same cycle -> CPU served first, DMA granted in the IDLE cycle right after DONE, one ack each.
3. dma_prio=1, MAX_DMA_STREAK=4, DMA held continuously requesting, cpu_req held -> 4 DMA accesses, then a CPU access, then the DMA streak restarts.
4. DMA write dma_addr=18'h3FFFF, dma_di=8'hC3 with dma_en=0 -> no grant. Then set dma_en=1 -> mem_we high with mem_addr=18'h3FFFF and mem_dout=8'hC3, dma_ack pulses.
5. Assert rst mid-CPU_ACC -> mem_oe/mem_we drop immediately, no cpu_ready, ctrl reads 8'h00 after release.
6. With PAGEMEM_ARB_STATS_EN: 3 DMA and 2 CPU accesses -> reg2=8'h03, reg3=8'h02. Write reg2 -> both read 0. Without the macro: both read 0 throughout.
